// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue
//
// Drives the RegisterFile write port. Writeback requests from the datapath
// are accepted over a valid/ready handshake into a small FIFO, and the FIFO
// drains one entry per cycle into a registered output stage that feeds the
// RegisterFile. Values that are queued or sitting in the output stage, but
// not yet committed, are forwarded onto both operand read paths.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   wb_valid/wb_ready   writeback request handshake
//   wb_addr, wb_data    destination register and value
//   rf_stall            RegisterFile write port unavailable; hold the queue
//   rf_write_register   RegisterFile write_register
//   rf_write_data       RegisterFile write_data
//   rf_write_enable     RegisterFile write_enable
//   read_register1/2    operand addresses
//   rf_data1/2          RegisterFile read data
//   data1/2             forwarded operands
//   count               queued entries, excluding the output stage
module regfile_writeback_queue #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       rf_stall,
    output logic [ADDR_W-1:0]          rf_write_register,
    output logic [DATA_W-1:0]          rf_write_data,
    output logic                       rf_write_enable,
    input  logic [ADDR_W-1:0]          read_register1,
    input  logic [ADDR_W-1:0]          read_register2,
    input  logic [DATA_W-1:0]          rf_data1,
    input  logic [DATA_W-1:0]          rf_data2,
    output logic [DATA_W-1:0]          data1,
    output logic [DATA_W-1:0]          data2,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              enq;
    logic              deq;

    // Ready depends only on the registered count: a full queue refuses a
    // request even when a drain happens on the same edge.
    assign wb_ready = (count != FULL);
    assign enq      = wb_valid && wb_ready;
    // Drain uses the pre-edge count, so an entry enqueued into an empty
    // queue is never drained on the same edge (no cut-through).
    assign deq      = (count != '0) && !rf_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            rf_write_enable   <= 1'b0;
            rf_write_register <= '0;
            rf_write_data     <= '0;
        end else begin
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (deq) begin
                head              <= head + 1'b1;
                rf_write_register <= mem_addr[head];
                rf_write_data     <= mem_data[head];
                rf_write_enable   <= 1'b1;
            end else begin
                rf_write_enable   <= 1'b0;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries outside the count window are never
    // read or forwarded.
    always_ff @(posedge clk) begin
        if (enq && !reset) begin
            mem_addr[tail] <= wb_addr;
            mem_data[tail] <= wb_data;
        end
    end

    // Forwarding. Lowest priority first: RegisterFile data, then the output
    // stage, then FIFO entries walked oldest-to-youngest from head so the
    // youngest match (nearest tail) wins, wrapping through the modulo index.
    logic [PTR_W-1:0] idx;

    always_comb begin
        idx   = '0;
        data1 = rf_data1;
        data2 = rf_data2;
        if (rf_write_enable && (rf_write_register == read_register1)) begin
            data1 = rf_write_data;
        end
        if (rf_write_enable && (rf_write_register == read_register2)) begin
            data2 = rf_write_data;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if (mem_addr[idx] == read_register1) begin
                    data1 = mem_data[idx];
                end
                if (mem_addr[idx] == read_register2) begin
                    data2 = mem_data[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench for regfile_writeback_queue: directed scenarios
// followed by randomized traffic, all compared against a queue-based
// reference model of the writeback path.
module tb_regfile_writeback_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [1:0]  wb_addr;
    logic [31:0] wb_data;
    logic        rf_stall;
    logic [1:0]  rf_write_register;
    logic [31:0] rf_write_data;
    logic        rf_write_enable;
    logic [1:0]  read_register1;
    logic [1:0]  read_register2;
    logic [31:0] rf_data1;
    logic [31:0] rf_data2;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [2:0]  count;

    regfile_writeback_queue #(.ADDR_W(2), .DATA_W(32), .DEPTH(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .wb_valid          (wb_valid),
        .wb_ready          (wb_ready),
        .wb_addr           (wb_addr),
        .wb_data           (wb_data),
        .rf_stall          (rf_stall),
        .rf_write_register (rf_write_register),
        .rf_write_data     (rf_write_data),
        .rf_write_enable   (rf_write_enable),
        .read_register1    (read_register1),
        .read_register2    (read_register2),
        .rf_data1          (rf_data1),
        .rf_data2          (rf_data2),
        .data1             (data1),
        .data2             (data2),
        .count             (count)
    );

    always #5 clk = ~clk;

    // Reference model: pending writes in acceptance order plus the
    // currently presented output stage.
    typedef struct packed {
        logic [1:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic        m_we   = 1'b0;
    logic [1:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Newest uncommitted value for a register, else the RegisterFile value.
    function automatic logic [31:0] exp_fwd(input logic [1:0] ra, input logic [31:0] rfd);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a == ra) return q[i].d;
        end
        if (m_we && m_addr == ra) return m_data;
        return rfd;
    endfunction

    task automatic model_edge();
        bit   e;
        bit   d;
        ent_t ent;
        if (reset) begin
            q.delete();
            m_we   = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            e = wb_valid && (q.size() != 4);
            d = (q.size() != 0) && !rf_stall;
            if (d) begin
                ent    = q.pop_front();
                m_we   = 1'b1;
                m_addr = ent.a;
                m_data = ent.d;
            end else begin
                m_we = 1'b0;
            end
            if (e) q.push_back('{a: wb_addr, d: wb_data});
        end
    endtask

    task automatic check_all();
        #1;
        chk("count",    64'(count),             64'(q.size()));
        chk("wb_ready", 64'(wb_ready),          64'(q.size() != 4));
        chk("we",       64'(rf_write_enable),   64'(m_we));
        chk("wreg",     64'(rf_write_register), 64'(m_addr));
        chk("wdata",    64'(rf_write_data),     64'(m_data));
        chk("data1",    64'(data1),             64'(exp_fwd(read_register1, rf_data1)));
        chk("data2",    64'(data2),             64'(exp_fwd(read_register2, rf_data2)));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic push(input logic [1:0] a, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        check_all();
        cycle();
        wb_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; rf_stall = 1'b0;
        read_register1 = '0; read_register2 = '0; rf_data1 = '0; rf_data2 = '0;
        cycle();

        // Reset then idle
        reset = 1'b0;
        rf_data1 = 32'hAAAA0000;
        check_all();
        chk("idle_count", 64'(count), 64'd0);
        chk("idle_ready", 64'(wb_ready), 64'd1);
        chk("idle_data1", 64'(data1), 64'hAAAA0000);
        cycle();

        // Single write
        push(2'd2, 32'h12345678);
        check_all();
        chk("single_count", 64'(count), 64'd1);
        cycle();
        check_all();
        chk("single_we", 64'(rf_write_enable), 64'd1);
        chk("single_data", 64'(rf_write_data), 64'h12345678);
        cycle();
        check_all();
        chk("single_we_off", 64'(rf_write_enable), 64'd0);

        // Fill under stall, fifth push refused
        rf_stall = 1'b1;
        for (int i = 0; i < 4; i++) push(2'(i), 32'h10 + 32'(i));
        push(2'd0, 32'h99);
        check_all();
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(wb_ready), 64'd0);
        rf_stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_all();
            cycle();
        end
        chk("drained_ready", 64'(wb_ready), 64'd1);

        // Forwarding priority: youngest queued entry wins
        rf_stall = 1'b1;
        read_register2 = 2'd1;
        rf_data2 = '0;
        push(2'd1, 32'h87654321);
        push(2'd1, 32'hDEADBEEF);
        check_all();
        chk("fwd_young", 64'(data2), 64'hDEADBEEF);
        rf_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_all();
            cycle();
        end
        rf_data2 = 32'h0BADF00D;
        check_all();

        // Sustained push with simultaneous drain across pointer wrap
        for (int i = 0; i < 10; i++) begin
            push(2'(i % 4), $urandom);
            if (i > 0) chk("wrap_count", 64'(count), 64'd1);
        end
        for (int i = 0; i < 3; i++) begin
            check_all();
            cycle();
        end

        // Reset mid-operation discards queued entries
        rf_stall = 1'b1;
        for (int i = 0; i < 3; i++) push(2'(i), 32'hC0 + 32'(i));
        reset = 1'b1;
        check_all();
        cycle();
        reset = 1'b0;
        rf_stall = 1'b0;
        check_all();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_we", 64'(rf_write_enable), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check_all();
            cycle();
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(0, 49) == 0);
            wb_valid       = ($urandom_range(0, 2) != 0);
            wb_addr        = 2'($urandom);
            wb_data        = $urandom;
            rf_stall       = ($urandom_range(0, 3) == 0);
            read_register1 = 2'($urandom);
            read_register2 = 2'($urandom);
            rf_data1       = $urandom;
            rf_data2       = $urandom;
            check_all();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
